apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
- Converts single-beat internal command requests into APB transfers on the APB bus.
- It is the requester end of the APB link; the register-block APB slave sits on the far side.
- Used by the block-level harness and by a future CPU-side bridge to drive register reads and writes.
- Handles wait states (pready), error responses (pslverr) and a bounded-wait timeout.

Parameters:
APB_ADDR_WIDTH, 8, width of paddr / cmd_addr
APB_DATA_WIDTH, 8, width of pwdata / prdata / cmd_wdata / rsp_rdata
TIMEOUT_CYCLES, 16, max ACCESS cycles with pready low before abort; 0 disables timeout
TMO_CNT_WIDTH, 8, width of wait counter; must satisfy TIMEOUT_CYCLES < 2**TMO_CNT_WIDTH

Ports:
pclk  input  1  APB clock; all logic on rising edge
preset  input  1  reset, asynchronous, active-high
cmd_valid  input  1  command request
cmd_ready  output  1  command accepted when cmd_valid & cmd_ready at rising edge
cmd_write  input  1  1 = write, 0 = read
cmd_addr  input  APB_ADDR_WIDTH  transfer address
cmd_wdata  input  APB_DATA_WIDTH  write data (ignored for reads)
rsp_valid  output  1  one-cycle response pulse
rsp_rdata  output  APB_DATA_WIDTH  read data; 0 for writes and timeouts
rsp_err  output  1  pslverr sampled, or timeout
rsp_timeout  output  1  transfer aborted by timeout
psel  output  1  APB select
penable  output  1  APB enable
pwrite  output  1  APB direction
paddr  output  APB_ADDR_WIDTH  APB address
pwdata  output  APB_DATA_WIDTH  APB write data
prdata  input  APB_DATA_WIDTH  APB read data
pready  input  1  APB ready
pslverr  input  1  APB slave error

Behaviour:
- Interface: one clock, pclk; reset preset is asynchronous and active-high.
- Reset values:
  - State IDLE.
  - psel = penable = pwrite = 0; paddr = pwdata = 0.
  - rsp_valid = rsp_err = rsp_timeout = 0; rsp_rdata = 0; wait counter = 0.
  - cmd_ready = 0 while preset is high.
- States: IDLE, SETUP, ACCESS (registered FSM). All APB outputs are registered.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, register cmd_write/cmd_addr/cmd_wdata into pwrite/paddr/pwdata, set psel = 1, go to SETUP.
- SETUP (exactly one cycle): psel = 1, penable = 0, cmd_ready = 0. Next state is unconditionally ACCESS, with penable = 1.
- ACCESS:
  - psel = 1, penable = 1; paddr/pwrite/pwdata held stable.
  - pready = 1 at an edge:
    - Capture rsp_rdata = pwrite ? 0 : prdata, rsp_err = pslverr, rsp_timeout = 0.
    - rsp_valid = 1 for the next cycle only.
    - Drop psel and penable, return to IDLE.
  - pready = 0: increment the wait counter.
  - Timeout: if TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES with pready still 0:
    - Abort: rsp_valid = 1, rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0.
    - psel and penable drop, return to IDLE.
  - Wait counter clears on entry to SETUP.
- pslverr and prdata are sampled only when psel & penable & pready; otherwise ignored.
- Latency with zero wait states:
  - Command accepted at edge E0.
  - SETUP during cycle after E0; ACCESS next cycle.
  - rsp_valid and cmd_ready both high 3 cycles after E0.
  - No back-to-back ACCESS→SETUP: one IDLE cycle minimum between transfers; peak rate one transfer per 3 cycles.
  - Each pready-low cycle adds one cycle.
- Held values:
  - paddr/pwrite/pwdata retain their last values in IDLE; they change only on accept.
  - rsp_rdata/rsp_err/rsp_timeout hold until the next response.
- cmd_valid while not in IDLE is ignored (cmd_ready = 0); the requester must hold it.
- Reset mid-transfer: all state clears immediately (asynchronous); psel/penable drop; no response is issued.
- pready = 1 on the same edge the counter would reach TIMEOUT_CYCLES: normal completion wins, and rsp_timeout = 0.

Test Plan:
- Write 0xA5 to 0x10 with pready tied 1 → SETUP cycle (psel = 1, penable = 0, paddr = 0x10, pwdata = 0xA5, pwrite = 1), then one ACCESS cycle; rsp_valid pulses 3 cycles after accept with rsp_err = 0, rsp_rdata = 0x00.
- Read 0x22 with slave returning prdata = 0x3C after 3 pready-low cycles → ACCESS lasts 4 cycles; paddr stable throughout; rsp_rdata = 0x3C, rsp_err = 0, rsp_valid a single cycle.
- Read with pslverr = 1 alongside pready = 1 → rsp_err = 1, rsp_timeout = 0, rsp_rdata = sampled prdata.
- pready held 0 with TIMEOUT_CYCLES = 16 → abort after 16 ACCESS wait cycles; rsp_err = 1, rsp_timeout = 1, psel = 0 next cycle; then a second command completes normally.
- Two commands issued back to back with cmd_valid held high → second accepted only in IDLE; psel low for exactly one cycle between transfers.
- preset asserted during ACCESS → psel/penable go to 0 without waiting for a clock edge; no rsp_valid; cmd_ready = 1 on the first edge after release.

Source files
------------

// File: rtl/apb_master_bridge.sv
// Single-beat command to APB requester bridge: registered IDLE/SETUP/ACCESS FSM
// with wait-state handling, slave error pass-through and a bounded-wait abort.
module apb_master_bridge #(
  parameter int APB_ADDR_WIDTH = 8,
  parameter int APB_DATA_WIDTH = 8,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TMO_CNT_WIDTH  = 8
) (
  input  logic                      pclk,
  input  logic                      preset,
  // Command handshake: a command is taken at a rising edge where cmd_valid and
  // cmd_ready are both high; the requester holds cmd_valid and the cmd_* fields
  // until then. Responses are a one-cycle rsp_valid pulse with no back-pressure.
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [APB_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [APB_DATA_WIDTH-1:0] cmd_wdata,
  output logic                      rsp_valid,
  output logic [APB_DATA_WIDTH-1:0] rsp_rdata,
  output logic                      rsp_err,
  output logic                      rsp_timeout,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [APB_ADDR_WIDTH-1:0] paddr,
  output logic [APB_DATA_WIDTH-1:0] pwdata,
  input  logic [APB_DATA_WIDTH-1:0] prdata,
  input  logic                      pready,
  input  logic                      pslverr,
  output logic [1:0]                state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam int unsigned TMO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  state_t                   state;
  logic [TMO_CNT_WIDTH-1:0] wait_cnt;
  logic                     tmo_hit;

  // Abort on the edge that would make the wait count reach TIMEOUT_CYCLES.
  assign tmo_hit   = (TIMEOUT_CYCLES != 0) && (wait_cnt == TMO_CNT_WIDTH'(TMO_LAST));
  assign state_dbg = state;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      cmd_ready   <= 1'b0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            pwrite    <= cmd_write;
            paddr     <= cmd_addr;
            pwdata    <= cmd_wdata;
            psel      <= 1'b1;
            cmd_ready <= 1'b0;
            wait_cnt  <= '0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          // Completion takes priority over the abort on the same edge.
          if (pready) begin
            rsp_rdata   <= pwrite ? '0 : prdata;
            rsp_err     <= pslverr;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            psel        <= 1'b0;
            penable     <= 1'b0;
            cmd_ready   <= 1'b1;
            state       <= IDLE;
          end else if (tmo_hit) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            psel        <= 1'b0;
            penable     <= 1'b0;
            cmd_ready   <= 1'b1;
            wait_cnt    <= wait_cnt + TMO_CNT_WIDTH'(1);
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + TMO_CNT_WIDTH'(1);
          end
        end
        default: begin
          psel      <= 1'b0;
          penable   <= 1'b0;
          cmd_ready <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: reset checks, a table of directed transfers,
// back-to-back and mid-transfer reset sequences, then random transfers.
module tb_apb_master_bridge;

  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int TMO = 16;

  logic          pclk = 1'b0;
  logic          preset = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata = '0;
  logic          pready = 1'b0;
  logic          pslverr = 1'b0;
  logic [1:0]    state_dbg;

  apb_master_bridge #(
    .APB_ADDR_WIDTH(AW),
    .APB_DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TMO),
    .TMO_CNT_WIDTH (8)
  ) dut (
    .pclk       (pclk),
    .preset     (preset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr),
    .state_dbg  (state_dbg)
  );

  // Clock / reset
  always #5 pclk = ~pclk;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [DW+1:0] exp_q[$];

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            waits;
    bit            slverr;
  } txn_t;

  typedef struct {
    txn_t          t;
    int            exp_access;
    logic [DW-1:0] exp_rdata;
    bit            exp_err;
    bit            exp_tmo;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference model: the slave holds pready low for t.waits ACCESS cycles.
  function automatic vec_t model(input txn_t t);
    vec_t v;
    v.t = t;
    if (TMO != 0 && t.waits >= TMO) begin
      v.exp_access = TMO;
      v.exp_rdata  = '0;
      v.exp_err    = 1'b1;
      v.exp_tmo    = 1'b1;
    end else begin
      v.exp_access = t.waits + 1;
      v.exp_rdata  = t.wr ? '0 : t.rdata;
      v.exp_err    = t.slverr;
      v.exp_tmo    = 1'b0;
    end
    return v;
  endfunction

  // Driver + APB slave for one transfer; starts and ends just after a falling edge.
  task automatic run_txn(input txn_t t, input vec_t e);
    int n;
    logic [DW+1:0] exp;
    exp_q.push_back({e.exp_tmo, e.exp_err, e.exp_rdata});
    cmd_valid = 1'b1;
    cmd_write = t.wr;
    cmd_addr  = t.addr;
    cmd_wdata = t.wdata;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge pclk);
      n++;
    end
    if (n >= 20) begin
      chk("accept_wait", 32'(cmd_ready), 1);
      cmd_valid = 1'b0;
      void'(exp_q.pop_front());
      return;
    end
    @(posedge pclk);
    #1;
    // Requester keeps cmd_valid high with different fields; the bridge must ignore them.
    cmd_addr  = AW'($urandom);
    cmd_wdata = DW'($urandom);
    cmd_write = ~t.wr;
    @(negedge pclk);
    chk("setup_psel", 32'(psel), 1);
    chk("setup_penable", 32'(penable), 0);
    chk("setup_paddr", 32'(paddr), 32'(t.addr));
    chk("setup_pwrite", 32'(pwrite), 32'(t.wr));
    chk("setup_pwdata", 32'(pwdata), 32'(t.wdata));
    chk("setup_cmd_ready", 32'(cmd_ready), 0);
    chk("setup_rsp_valid", 32'(rsp_valid), 0);
    pready  = 1'b1;
    pslverr = 1'b1;
    prdata  = DW'($urandom);
    @(negedge pclk);
    n = 0;
    while (psel && penable && n < TMO + 8) begin
      n++;
      chk("access_paddr", 32'(paddr), 32'(t.addr));
      pready  = (n > t.waits);
      pslverr = pready ? t.slverr : 1'($urandom);
      prdata  = pready ? t.rdata : DW'($urandom);
      @(negedge pclk);
    end
    pready    = 1'b0;
    pslverr   = 1'b0;
    cmd_valid = 1'b0;
    exp = exp_q.pop_front();
    chk("access_cycles", 32'(n), 32'(e.exp_access));
    chk("done_psel", 32'(psel), 0);
    chk("done_penable", 32'(penable), 0);
    chk("rsp_valid", 32'(rsp_valid), 1);
    chk("rsp_rdata", 32'(rsp_rdata), 32'(exp[DW-1:0]));
    chk("rsp_err", 32'(rsp_err), 32'(exp[DW]));
    chk("rsp_timeout", 32'(rsp_timeout), 32'(exp[DW+1]));
    chk("done_cmd_ready", 32'(cmd_ready), 1);
  endtask

  vec_t tbl[7];

  initial begin
    txn_t a;
    txn_t b;
    tbl[0] = '{'{1'b1, 8'h10, 8'hA5, 8'h00, 0,  1'b0}, 1,  8'h00, 1'b0, 1'b0};
    tbl[1] = '{'{1'b0, 8'h22, 8'h00, 8'h3C, 3,  1'b0}, 4,  8'h3C, 1'b0, 1'b0};
    tbl[2] = '{'{1'b0, 8'h40, 8'h00, 8'h99, 0,  1'b1}, 1,  8'h99, 1'b1, 1'b0};
    tbl[3] = '{'{1'b0, 8'h55, 8'h00, 8'h77, 20, 1'b0}, 16, 8'h00, 1'b1, 1'b1};
    tbl[4] = '{'{1'b1, 8'h7F, 8'hC3, 8'h00, 15, 1'b0}, 16, 8'h00, 1'b0, 1'b0};
    tbl[5] = '{'{1'b0, 8'h01, 8'h00, 8'h11, 16, 1'b0}, 16, 8'h00, 1'b1, 1'b1};
    tbl[6] = '{'{1'b1, 8'h33, 8'h5A, 8'h00, 2,  1'b1}, 3,  8'h00, 1'b1, 1'b0};

    // Reset state
    #2 preset = 1'b1;
    @(negedge pclk);
    chk("rst_psel", 32'(psel), 0);
    chk("rst_penable", 32'(penable), 0);
    chk("rst_pwrite", 32'(pwrite), 0);
    chk("rst_paddr", 32'(paddr), 0);
    chk("rst_pwdata", 32'(pwdata), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    chk("rst_rsp_timeout", 32'(rsp_timeout), 0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
    chk("rst_cmd_ready", 32'(cmd_ready), 0);
    chk("rst_state", 32'(state_dbg), 0);
    @(negedge pclk);
    preset = 1'b0;
    @(negedge pclk);
    chk("post_rst_cmd_ready", 32'(cmd_ready), 1);

    // Directed table
    for (int i = 0; i < 7; i++) begin
      run_txn(tbl[i].t, tbl[i]);
      @(negedge pclk);
      chk("idle_rsp_valid", 32'(rsp_valid), 0);
      chk("idle_rsp_rdata_hold", 32'(rsp_rdata), 32'(tbl[i].exp_rdata));
      chk("idle_paddr_hold", 32'(paddr), 32'(tbl[i].t.addr));
      chk("idle_psel", 32'(psel), 0);
    end

    // Back to back: second command offered the moment the first completes
    a = '{1'b1, 8'hA0, 8'h12, 8'h00, 1, 1'b0};
    b = '{1'b0, 8'hB0, 8'h00, 8'hE7, 0, 1'b0};
    run_txn(a, model(a));
    run_txn(b, model(b));
    @(negedge pclk);

    // Reset asserted in the middle of ACCESS
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 8'h66;
    @(posedge pclk);
    #1 cmd_valid = 1'b0;
    pready = 1'b0;
    @(negedge pclk);
    @(negedge pclk);
    chk("mid_access_state", 32'(state_dbg), 2);
    chk("mid_access_penable", 32'(penable), 1);
    #2 preset = 1'b1;
    #1;
    chk("async_rst_psel", 32'(psel), 0);
    chk("async_rst_penable", 32'(penable), 0);
    chk("async_rst_cmd_ready", 32'(cmd_ready), 0);
    @(negedge pclk);
    chk("rst_no_rsp", 32'(rsp_valid), 0);
    preset = 1'b0;
    @(negedge pclk);
    chk("rel_cmd_ready", 32'(cmd_ready), 1);
    chk("rel_no_rsp", 32'(rsp_valid), 0);

    // Random transfers against the model
    for (int i = 0; i < 40; i++) begin
      txn_t r;
      r.wr     = 1'($urandom);
      r.addr   = AW'($urandom);
      r.wdata  = DW'($urandom);
      r.rdata  = DW'($urandom);
      r.slverr = ($urandom_range(0, 3) == 0);
      r.waits  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(12, 20))
                                             : int'($urandom_range(0, 3));
      run_txn(r, model(r));
      if ($urandom_range(0, 1) == 1) @(negedge pclk);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
